// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM-stage data-memory access unit (req/ack port, stall, misalign and timeout flags)
module mem_access_stage #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        Clk_40,
  input  logic        Reset_40,
  input  logic        MemRead_40,
  input  logic        MemWrite_40,
  input  logic [1:0]  Size_40,
  input  logic        SignExt_40,
  input  logic [31:0] Address_40,
  input  logic [31:0] StoreData_40,
  output logic        DMemReq_40,
  output logic        DMemWe_40,
  output logic [31:0] DMemAddr_40,
  output logic [3:0]  DMemBE_40,
  output logic [31:0] DMemWData_40,
  input  logic [31:0] DMemRData_40,
  input  logic        DMemAck_40,
  output logic [31:0] ReadDataFromMem_MEM_40,
  output logic        MemStall_40,
  output logic        MisalignExc_40,
  output logic        BusErr_40
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic        sext_q, sext_d;
  logic        misal_q, misal_d;
  logic        buserr_q, buserr_d;
  logic        stall;

  logic        op, is_half, is_word, misaligned;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] load_val;
  logic [31:0] rshift;

  assign op         = MemRead_40 | MemWrite_40;
  assign is_half    = (Size_40 == 2'b01);
  assign is_word    = Size_40[1];
  assign misaligned = (is_half & Address_40[0]) | (is_word & (|Address_40[1:0]));

  always_comb begin
    fmt_be    = 4'b1111;
    fmt_wdata = StoreData_40;
    if (MemWrite_40) begin
      if (Size_40 == 2'b00) begin
        fmt_be    = 4'b0001 << Address_40[1:0];
        fmt_wdata = {4{StoreData_40[7:0]}};
      end else if (is_half) begin
        fmt_be    = Address_40[1] ? 4'b1100 : 4'b0011;
        fmt_wdata = {2{StoreData_40[15:0]}};
      end
    end
  end

  // Lane selection uses the request attributes captured at issue, not the live inputs.
  assign rshift = DMemRData_40 >> {lane_q, 3'b000};
  always_comb begin
    case (size_q)
      2'b00:   load_val = {{24{sext_q & rshift[7]}}, rshift[7:0]};
      2'b01:   load_val = {{16{sext_q & rshift[15]}}, rshift[15:0]};
      default: load_val = DMemRData_40;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    be_d     = be_q;
    we_d     = we_q;
    size_d   = size_q;
    lane_d   = lane_q;
    sext_d   = sext_q;
    misal_d  = 1'b0;
    buserr_d = 1'b0;
    stall    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op) begin
          if (misaligned) begin
            misal_d = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = S_REQ;
            cnt_d   = 8'd0;
            addr_d  = {Address_40[31:2], 2'b00};
            wdata_d = fmt_wdata;
            be_d    = fmt_be;
            we_d    = MemWrite_40;
            size_d  = Size_40;
            lane_d  = Address_40[1:0];
            sext_d  = SignExt_40;
          end
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (DMemAck_40) begin
          if (!we_q) rdata_d = load_val;
          state_d = S_DONE;
        end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
          buserr_d = 1'b1;
          if (!we_q) rdata_d = 32'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge Clk_40) begin
    if (!Reset_40) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      be_q     <= 4'd0;
      we_q     <= 1'b0;
      size_q   <= 2'd0;
      lane_q   <= 2'd0;
      sext_q   <= 1'b0;
      misal_q  <= 1'b0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
      size_q   <= size_d;
      lane_q   <= lane_d;
      sext_q   <= sext_d;
      misal_q  <= misal_d;
      buserr_q <= buserr_d;
    end
  end

  assign DMemReq_40             = (state_q == S_REQ);
  assign DMemWe_40              = we_q;
  assign DMemAddr_40            = addr_q;
  assign DMemBE_40              = be_q;
  assign DMemWData_40           = wdata_q;
  assign ReadDataFromMem_MEM_40 = rdata_q;
  assign MemStall_40            = stall & Reset_40;
  assign MisalignExc_40         = misal_q;
  assign BusErr_40              = buserr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage against a behavioural access model
module tb_mem_access_stage;
  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst_n, mem_read, mem_write, sext, ack;
  logic [1:0]  size;
  logic [31:0] addr, sdata, rdata;
  logic        req, we, stall, mis, berr;
  logic [31:0] daddr, wdata, rres;
  logic [3:0]  be;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_res;

  always #5 clk = ~clk;

  mem_access_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .Clk_40(clk), .Reset_40(rst_n), .MemRead_40(mem_read), .MemWrite_40(mem_write),
    .Size_40(size), .SignExt_40(sext), .Address_40(addr), .StoreData_40(sdata),
    .DMemReq_40(req), .DMemWe_40(we), .DMemAddr_40(daddr), .DMemBE_40(be),
    .DMemWData_40(wdata), .DMemRData_40(rdata), .DMemAck_40(ack),
    .ReadDataFromMem_MEM_40(rres), .MemStall_40(stall), .MisalignExc_40(mis), .BusErr_40(berr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One instruction held on the EX/MEM inputs until the pipeline advances; ack_at<0 never acks.
  task automatic access(input bit wr, input logic [1:0] sz, input bit sx, input logic [31:0] a,
                        input logic [31:0] sd, input int ack_at, input logic [31:0] rd);
    bit          misal, acked, timeout;
    int          lane, nreq;
    logic [31:0] exp_be, exp_wd, v;
    misal = (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0);
    lane  = a % 4;
    exp_be = 32'hF;
    exp_wd = sd;
    if (wr && sz == 2'd0) begin
      exp_be = 32'd1 << lane;
      exp_wd = (sd & 32'hFF) * 32'h0101_0101;
    end else if (wr && sz == 2'd1) begin
      exp_be = (lane >= 2) ? 32'hC : 32'h3;
      exp_wd = (sd & 32'hFFFF) * 32'h0001_0001;
    end
    if (sz == 2'd0) begin
      v = (rd >> (8 * lane)) & 32'hFF;
      if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * (lane / 2))) & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end

    mem_read = !wr; mem_write = wr; size = sz; sext = sx; addr = a; sdata = sd;
    #1 chk("stall_issue", stall, !misal);
    step();
    if (misal) begin
      chk("misal_pulse", mis, 1);
      chk("misal_noreq", req, 0);
      chk("misal_nostall", stall, 0);
      mem_read = 0; mem_write = 0;
      step();
      chk("misal_once", mis, 0);
      chk("misal_idle_req", req, 0);
      return;
    end
    nreq = 0; acked = 0; timeout = 0;
    while (!acked && !timeout && nreq < MAX_WAIT + 2) begin
      chk("req_high", req, 1);
      chk("req_stall", stall, 1);
      chk("req_addr", daddr, a & 32'hFFFF_FFFC);
      chk("req_be", be, exp_be);
      chk("req_we", we, wr);
      if (wr) chk("req_wdata", wdata, exp_wd);
      ack   = (nreq == ack_at);
      rdata = ack ? rd : $urandom;
      nreq++;
      step();
      if (ack) acked = 1;
      else if (nreq == MAX_WAIT) timeout = 1;
    end
    ack = 0;
    if (!wr) exp_res = acked ? v : 32'd0;
    chk("done_stall", stall, 0);
    chk("done_req", req, 0);
    chk("done_buserr", berr, timeout);
    chk("done_misal", mis, 0);
    chk("done_result", rres, exp_res);
    mem_read = 0; mem_write = 0;
    step();
    chk("idle_buserr", berr, 0);
    chk("idle_req", req, 0);
    chk("idle_stall", stall, 0);
    chk("idle_result", rres, exp_res);
  endtask

  initial begin
    rst_n = 0; mem_read = 0; mem_write = 0; size = 0; sext = 0;
    addr = 0; sdata = 0; rdata = 0; ack = 0; exp_res = 0;
    repeat (3) step();
    chk("rst_req", req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_result", rres, 0);
    chk("rst_be", be, 0);
    rst_n = 1;
    step();

    access(0, 2'd0, 1, 32'h0000_1003, 32'h0, 0, 32'h80FF_1234);
    chk("t1_lb", rres, 32'hFFFF_FF80);
    access(0, 2'd0, 0, 32'h0000_1003, 32'h0, 0, 32'h80FF_1234);
    chk("t1_lbu", rres, 32'h0000_0080);
    access(1, 2'd1, 0, 32'h0000_1002, 32'h1234_BEEF, 0, 32'h0);
    chk("t2_sh_hold", rres, 32'h0000_0080);
    access(0, 2'd2, 0, 32'h0000_2000, 32'h0, 3, 32'hDEAD_BEEF);
    chk("t3_lw", rres, 32'hDEAD_BEEF);
    access(0, 2'd2, 0, 32'h0000_2001, 32'h0, 0, 32'h0);
    access(0, 2'd1, 1, 32'h0000_2003, 32'h0, 0, 32'h0);
    access(0, 2'd0, 1, 32'h0000_2003, 32'h0, 0, 32'h7F00_0000);
    chk("t4_lb_odd", rres, 32'h0000_007F);
    access(0, 2'd2, 0, 32'h0000_3000, 32'h0, -1, 32'h0);
    chk("t5_timeout", rres, 32'h0);

    mem_read = 1; size = 2'd2; addr = 32'h0000_3004; sext = 0;
    step();
    chk("t6_in_req", req, 1);
    rst_n = 0; ack = 1; rdata = 32'h5555_AAAA;
    #1 chk("t6_stall_in_rst", stall, 0);
    step();
    chk("t6_req", req, 0);
    chk("t6_we", we, 0);
    chk("t6_addr", daddr, 0);
    chk("t6_be", be, 0);
    chk("t6_wdata", wdata, 0);
    chk("t6_result", rres, 0);
    chk("t6_misal", mis, 0);
    chk("t6_buserr", berr, 0);
    rst_n = 1; ack = 0; mem_read = 0;
    step();
    chk("t6_idle", req, 0);
    chk("t6_not_captured", rres, 0);
    exp_res = 0;
    access(1, 2'd2, 0, 32'h0000_4000, 32'hCAFE_F00D, 1, 32'h0);

    for (int i = 0; i < 40; i++) begin
      access($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
             $urandom, $urandom, $urandom_range(0, 4), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage data-memory access unit of the 5-stage MIPS pipeline.
- Sits between the EX/MEM register and the MEM/WB register, and drives the MEM/WB register's ReadDataFromMem_MEM input.
- Converts lb/lbu/lh/lhu/lw/sb/sh/sw requests into word-aligned, byte-enabled transactions on a req/ack data-memory port.
- Stalls the pipeline while a transaction is outstanding; flags misaligned accesses and bus timeouts.

Parameters:
MAX_WAIT, 15, number of REQ cycles without ack before a bus timeout is declared (range 1..255).

Ports:
Clk_40  in  1  clock; all state updates on rising edge.
Reset_40  in  1  synchronous, active-low reset.
MemRead_40  in  1  load request (from EX/MEM register).
MemWrite_40  in  1  store request; has priority if both request inputs are high.
Size_40  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
SignExt_40  in  1  1 = sign-extend a byte/half load, 0 = zero-extend.
Address_40  in  32  byte address (ALU result).
StoreData_40  in  32  store data (rt value, right-justified).
DMemReq_40  out  1  memory request; held high until ack or timeout.
DMemWe_40  out  1  1 = write.
DMemAddr_40  out  32  word address {Address_40[31:2],2'b00}.
DMemBE_40  out  4  byte enables; bit i = bits [8i+7:8i].
DMemWData_40  out  32  lane-replicated write data.
DMemRData_40  in  32  read data; valid when DMemAck_40 is high.
DMemAck_40  in  1  memory completion, sampled at the clock edge.
ReadDataFromMem_MEM_40  out  32  aligned and extended load result.
MemStall_40  out  1  combinational stall to the hazard unit (freezes PC, IF/ID, ID/EX, EX/MEM; MEM/WB holds).
MisalignExc_40  out  1  one-cycle misalignment pulse.
BusErr_40  out  1  one-cycle timeout pulse.

Behaviour:
- Byte order: little-endian; byte lane = Address_40[1:0].
- op = MemRead_40 | MemWrite_40.
- Misaligned:
  - half with Address_40[0]=1;
  - word with Address_40[1:0]!=0.
- States:
  - IDLE: op & aligned → REQ, MemStall_40=1 combinationally. op & misaligned → no request, MisalignExc_40=1 next cycle, no stall, stay IDLE. No op → stay IDLE. DMemAck_40 is ignored in IDLE.
  - REQ: DMemReq_40=1. Address, data, BE and We are registered on IDLE→REQ and held stable. MemStall_40=1. Wait counter increments each cycle.
    - Ack=1 → latch the extended load data (loads only), → DONE.
    - Counter reaches MAX_WAIT without ack → DMemReq_40 drops, BusErr_40=1 for one cycle, ReadDataFromMem_MEM_40=0 for a load, → DONE.
  - DONE: MemStall_40=0 for exactly one cycle, so the pipeline advances on this edge. Unconditionally → IDLE, which prevents re-triggering on the held instruction.
- Latency: zero-wait memory (ack in the first REQ cycle) gives 3 cycles, op presented to stall release. Each wait cycle adds 1.
- Load extraction:
  - byte: lane Address_40[1:0], bit 7 replicated if SignExt_40, else zeros;
  - half: lane Address_40[1] (bytes 1:0 or 3:2), bit 15 extended the same way;
  - word: unchanged.
- Store formatting:
  - byte: data[7:0] replicated ×4, BE = 1<<Address_40[1:0];
  - half: data[15:0] replicated ×2, BE = 0011 or 1100;
  - word: BE = 1111.
- Reads use BE = 1111.
- ReadDataFromMem_MEM_40 holds its last value on stores, no-ops and misaligned accesses.
- Reset (Reset_40=0 at an edge), including mid-REQ:
  - state → IDLE, counter → 0;
  - all outputs 0: DMemReq_40, DMemWe_40, DMemAddr_40, DMemBE_40, DMemWData_40, ReadDataFromMem_MEM_40, MisalignExc_40, BusErr_40;
  - MemStall_40=0 while reset is low;
  - an ack coinciding with reset is discarded.

Test Plan:
1. lb at 0x0000_1003, RData 0x80FF_1234, ack in the first REQ cycle → ReadDataFromMem_MEM_40=0xFFFF_FF80 in DONE. Repeat as lbu → 0x0000_0080. MemStall_40 high exactly 2 cycles in each case.
2. sh at 0x0000_1002, StoreData 0x1234_BEEF → DMemAddr_40=0x0000_1000, DMemBE_40=1100, DMemWData_40=0xBEEF_BEEF, DMemWe_40=1. ReadDataFromMem_MEM_40 unchanged.
3. lw at 0x0000_2000, ack withheld 3 cycles then RData 0xDEAD_BEEF → DMemReq_40 high 4 cycles with stable address. MemStall_40 high 5 cycles. Result 0xDEAD_BEEF.
4. lw at 0x0000_2001 → DMemReq_40 never rises, MemStall_40 stays 0, MisalignExc_40 pulses 1 cycle. Same for lh at odd address; lb at odd address is legal.
5. Ack never returned, MAX_WAIT=15 → DMemReq_40 drops after 15 REQ cycles, BusErr_40 pulses once, load result 0, then IDLE.
6. Reset_40 low during REQ with ack in the same cycle → next cycle all outputs 0, state IDLE, the acked data is not captured. A subsequent sw completes normally.
